red_lane_tx: RTL and testbench
==============================

Name: red_lane_tx

Overview:
- Transmit side of the nibble-lane reduction interface.
- Accepts a pair of 16-bit operands (A, B) through a valid/ready handshake and streams them to a lane-serial reduction engine, one nibble pair per beat, LSB lane first.
- Each beat carries the A-lane and B-lane nibble, the lane index, and first/last markers, so the receiver can rebuild the byte-pair sums without holding full words.
- Sits between the execute-stage operand latch and the serial RED datapath.

Parameters:
- WORD_W, 16, operand width in bits; must be a multiple of LANE_W.
- LANE_W, 4, lane (nibble) width in bits.
- NLANES, WORD_W/LANE_W (=4), beats per operand pair; derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  WORD_W  operand A.
- in_b  input  WORD_W  operand B.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_a  output  LANE_W  current A lane.
- out_b  output  LANE_W  current B lane.
- out_idx  output  clog2(NLANES)  lane index of current beat.
- out_first  output  1  beat is lane 0.
- out_last  output  1  beat is lane NLANES-1.
- busy  output  1  an operand pair is held (IDLE is not the state).

Behaviour:
- State machine, two states:
  - IDLE: no pair held.
  - SEND: pair held in a shadow register, beats issuing.
- Reset (async on rst_n low; state updates on the clk rising edge thereafter):
  - State IDLE, lane counter 0, shadow registers 0.
  - out_valid 0, out_a/out_b/out_idx 0, out_first 0, out_last 0, busy 0.
  - in_ready 1 after reset deasserts.
- in_ready:
  - 1 in IDLE.
  - In SEND, 1 only in a cycle where out_valid & out_ready & out_last (back-to-back refill).
  - Combinational from state, counter and out_ready.
- Input accept (in_valid & in_ready, rising edge):
  - Capture in_a/in_b into the shadow registers, set counter to 0, go to SEND.
  - out_valid rises the next cycle. Latency: accept edge to first beat is 1 cycle.
- In SEND, outputs are registered/shadow-derived and stable while out_valid & !out_ready:
  - out_valid = 1.
  - out_a = shadow_a[idx*LANE_W +: LANE_W], out_b likewise from shadow_b.
  - out_idx = counter.
  - out_first = (counter==0), out_last = (counter==NLANES-1).
- Beat handshake (out_valid & out_ready):
  - If not last: counter+1.
  - If last and no new accept that cycle: go to IDLE, counter 0, out_valid 0 next cycle.
  - If last and in_valid that same cycle: accept the new pair, stay in SEND, counter 0, no idle bubble.
- Full throughput: NLANES beats per pair, with out_ready held 1 and in_valid held 1.
- Backpressure: out_ready low holds all out_* and the counter unchanged. No beat is dropped or duplicated.
- The upstream pair is captured only on accept. in_a/in_b changes while busy are ignored.
- Counter never exceeds NLANES-1; wrap goes only to 0, via last-beat handling.
- Outputs in IDLE: out_a, out_b, out_idx, out_first and out_last are driven 0.
- Reset mid-stream aborts the pair; after reset no partial beats resume.
- No arithmetic is performed. Lanes are raw unsigned slices; sign handling belongs to the receiver.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, busy=0, all out_* 0.
- A=16'hA5C3, B=16'h1F72, out_ready=1 -> beats (a,b,idx) = (3,2,0 first), (C,7,1), (5,F,2), (A,1,3 last); then IDLE next cycle.
- Same pair, out_ready low for 3 cycles during beat idx=1 -> out_a=C, out_b=7, idx=1 held stable; sequence resumes with no loss or duplication.
- Back-to-back: pair1 (16'h1234, 16'h5678) then pair2 (16'hFFFF, 16'h0001) with in_valid held high -> 8 consecutive valid beats, in_ready=1 only on pair1's last beat, no bubble.
- rst_n pulsed low during beat idx=2 -> outputs go to reset values immediately; the next accepted pair starts at idx=0 with out_first=1.
- in_a changed while busy and in_valid low -> streamed lanes reflect the originally captured value only.

Source files
------------

// File: rtl/red_lane_tx_if.sv
// Operand/beat bus of the nibble-lane reduction transmitter.
// The master side supplies operand pairs and accepts beats; the slave side
// is the transmitter itself.
interface red_lane_tx_if #(
    parameter int WORD_W = 16,
    parameter int LANE_W = 4
);
    localparam int NLANES = WORD_W / LANE_W;
    localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

    // upstream operand handshake
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_a;
    logic [WORD_W-1:0] in_b;

    // downstream beat handshake
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] out_a;
    logic [LANE_W-1:0] out_b;
    logic [IDX_W-1:0]  out_idx;
    logic              out_first;
    logic              out_last;

    // status
    logic              busy;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_a,
        input  out_b,
        input  out_idx,
        input  out_first,
        input  out_last,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_a,
        output out_b,
        output out_idx,
        output out_first,
        output out_last,
        output busy
    );
endinterface

// File: rtl/red_lane_tx.sv
// Transmit side of the nibble-lane reduction interface.
// Captures an operand pair (A, B) on accept and streams it LSB lane first,
// one A/B nibble pair per beat, tagged with lane index and first/last marks.
// All beat outputs come straight from flops so they hold still under
// backpressure. WORD_W must be a multiple of LANE_W.
module red_lane_tx #(
    parameter int WORD_W = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    red_lane_tx_if.slave     bus
);
    localparam int NLANES = WORD_W / LANE_W;
    localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLANES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Pick lane idx out of a word; out-of-range indices yield zero.
    function automatic logic [LANE_W-1:0] lane_sel(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  idx
    );
        logic [LANE_W-1:0] r;
        r = {LANE_W{1'b0}};
        for (int i = 0; i < NLANES; i++) begin
            r = (idx == IDX_W'(i)) ? word[i*LANE_W +: LANE_W] : r;
        end
        return r;
    endfunction

    state_t            state_q,     state_d;
    logic [IDX_W-1:0]  cnt_q,       cnt_d;
    logic [WORD_W-1:0] shadow_a_q,  shadow_a_d;
    logic [WORD_W-1:0] shadow_b_q,  shadow_b_d;
    logic              out_valid_q, out_valid_d;
    logic [LANE_W-1:0] out_a_q,     out_a_d;
    logic [LANE_W-1:0] out_b_q,     out_b_d;
    logic [IDX_W-1:0]  out_idx_q,   out_idx_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q,  out_last_d;

    logic beat_done_s;
    logic last_s;
    logic in_ready_s;
    logic accept_s;

    // A beat leaves when the downstream takes it; the last beat frees the
    // shadow, which lets a new pair be taken in the same cycle.
    assign beat_done_s = out_valid_q & bus.out_ready;
    assign last_s      = (cnt_q == LAST_IDX);
    assign in_ready_s  = (state_q == ST_IDLE) | (beat_done_s & last_s);
    assign accept_s    = bus.in_valid & in_ready_s;

    // Next state, lane counter and shadow capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d    = ST_SEND;
                    cnt_d      = IDX_ZERO;
                    shadow_a_d = bus.in_a;
                    shadow_b_d = bus.in_b;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = IDX_ZERO;
                end
            end
            ST_SEND: begin
                if (beat_done_s) begin
                    if (last_s) begin
                        if (accept_s) begin
                            // back-to-back refill, no idle bubble
                            state_d    = ST_SEND;
                            cnt_d      = IDX_ZERO;
                            shadow_a_d = bus.in_a;
                            shadow_b_d = bus.in_b;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = IDX_ZERO;
                        end
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end else begin
                    // stalled: hold everything
                    state_d = state_q;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = IDX_ZERO;
            end
        endcase
    end

    // Beat outputs for the next cycle, derived from next state so they are
    // registered; recomputing from held state keeps them stable on a stall.
    always_comb begin
        out_valid_d = 1'b0;
        out_a_d     = {LANE_W{1'b0}};
        out_b_d     = {LANE_W{1'b0}};
        out_idx_d   = IDX_ZERO;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        if (state_d == ST_SEND) begin
            out_valid_d = 1'b1;
            out_a_d     = lane_sel(shadow_a_d, cnt_d);
            out_b_d     = lane_sel(shadow_b_d, cnt_d);
            out_idx_d   = cnt_d;
            out_first_d = (cnt_d == IDX_ZERO);
            out_last_d  = (cnt_d == LAST_IDX);
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // State, counter, shadow and output registers with async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= IDX_ZERO;
            shadow_a_q  <= {WORD_W{1'b0}};
            shadow_b_q  <= {WORD_W{1'b0}};
            out_valid_q <= 1'b0;
            out_a_q     <= {LANE_W{1'b0}};
            out_b_q     <= {LANE_W{1'b0}};
            out_idx_q   <= IDX_ZERO;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_a_q  <= shadow_a_d;
            shadow_b_q  <= shadow_b_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_idx_q   <= out_idx_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q == ST_SEND);

endmodule

// File: tb/tb_red_lane_tx.sv
// Scoreboard bench for red_lane_tx: the driver pushes the expected beats of
// each accepted pair; a monitor on the falling edge compares and pops.
module tb_red_lane_tx;
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] idx;
        logic       first;
        logic       last;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    beat_t exp_q[$];

    red_lane_tx_if #(.WORD_W(16), .LANE_W(4)) bus_if ();

    red_lane_tx #(.WORD_W(16), .LANE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: a pair of words becomes four beats, lane i = (w >> 4i) mod 16.
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        beat_t bt;
        for (int i = 0; i < 4; i++) begin
            bt.a     = 4'((a >> (4 * i)) % 16);
            bt.b     = 4'((b >> (4 * i)) % 16);
            bt.idx   = 2'(i);
            bt.first = (i == 0);
            bt.last  = (i == 3);
            exp_q.push_back(bt);
        end
    endtask

    // Monitor: reset values, idle zeros, in_ready/busy and beat contents.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
            chk("rst_busy",  32'(bus_if.busy),      32'd0);
            chk("rst_data",  {20'd0, bus_if.out_a, bus_if.out_b, bus_if.out_idx,
                              bus_if.out_first, bus_if.out_last}, 32'd0);
            exp_q.delete();
        end else begin
            logic held;
            logic rdy_exp;
            held    = (exp_q.size() != 0);
            rdy_exp = !held || (exp_q.size() == 1 && bus_if.out_ready);
            chk("out_valid", 32'(bus_if.out_valid), 32'(held));
            chk("busy",      32'(bus_if.busy),      32'(held));
            chk("in_ready",  32'(bus_if.in_ready),  32'(rdy_exp));
            if (held) begin
                chk("beat_a",     32'(bus_if.out_a),     32'(exp_q[0].a));
                chk("beat_b",     32'(bus_if.out_b),     32'(exp_q[0].b));
                chk("beat_idx",   32'(bus_if.out_idx),   32'(exp_q[0].idx));
                chk("beat_first", 32'(bus_if.out_first), 32'(exp_q[0].first));
                chk("beat_last",  32'(bus_if.out_last),  32'(exp_q[0].last));
                if (bus_if.out_ready) void'(exp_q.pop_front());
            end else begin
                chk("idle_data", {20'd0, bus_if.out_a, bus_if.out_b, bus_if.out_idx,
                                  bus_if.out_first, bus_if.out_last}, 32'd0);
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic ordy, output logic acc);
        bus_if.in_valid  = v;
        bus_if.in_a      = a;
        bus_if.in_b      = b;
        bus_if.out_ready = ordy;
        #1;
        acc = v && bus_if.in_ready && rst_n;
        @(posedge clk);
        if (acc) push_pair(a, b);
        #1;
    endtask

    task automatic idle_step(input logic ordy);
        logic acc;
        step(1'b0, 16'($urandom), 16'($urandom), ordy, acc);
    endtask

    task automatic do_reset();
        bus_if.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_step(1'b1);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic acc;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = 16'h0000;
        bus_if.in_b      = 16'h0000;
        bus_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_step(1'b1);
        idle_step(1'b0);

        // basic pair, no backpressure
        step(1'b1, 16'hA5C3, 16'h1F72, 1'b1, acc);
        chk("accept_basic", 32'(acc), 32'd1);
        repeat (5) idle_step(1'b1);

        // stall three cycles on beat 1
        step(1'b1, 16'hA5C3, 16'h1F72, 1'b1, acc);
        idle_step(1'b1);
        repeat (3) idle_step(1'b0);
        repeat (4) idle_step(1'b1);
        drain();

        // back-to-back with in_valid held high
        step(1'b1, 16'h1234, 16'h5678, 1'b1, acc);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) step(1'b1, 16'hFFFF, 16'h0001, 1'b1, acc);
        chk("accept_b2b", 32'(acc), 32'd1);
        repeat (5) idle_step(1'b1);

        // reset while beat 2 is presented
        step(1'b1, 16'hA5C3, 16'h1F72, 1'b1, acc);
        repeat (2) idle_step(1'b1);
        do_reset();
        step(1'b1, 16'h0F0F, 16'hBEEF, 1'b1, acc);
        chk("accept_after_rst", 32'(acc), 32'd1);
        drain();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                     ($urandom_range(0, 3) != 0), acc);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
